// File: rtl/pwm_capture_if.sv
// Wishbone slave bus used by pwm_capture: 16-bit data, 3 decoded address bits.
interface pwm_capture_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (output cyc, stb, we, adr, wdata, input ack, rdata);
  modport slave  (input cyc, stb, we, adr, wdata, output ack, rdata);
endinterface

// File: rtl/pwm_capture.sv
// Single-channel PWM decoder: measures period and high time of i_pwm in prescaled ticks
// and exposes the results through a 16-bit Wishbone register file.
module pwm_capture #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  pwm_capture_if.slave wb,
  input  logic         i_pwm,
  output logic         o_irq
);

  typedef enum logic [1:0] {StIdle, StArm, StHigh, StLow} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_q;
  logic [3:0]             ctrl_q, ctrl_d;
  logic [15:0]            divisor_q, timeout_q, period_q, high_q;
  logic                   valid_q, tout_q, ovf_q, divinv_q;
  logic [15:0]            cnt_q, cnt_d, hi_cnt_q, hi_cnt_d, div_q, div_d;
  logic                   ack_q, irq_q;
  logic [15:0]            rdata_q, rdata_d;

  logic        acc, wr;
  logic [2:0]  sel;
  logic [3:0]  w1c;
  logic        pwm_in, rise, fall, tick, cnt_sat, tout_hit;
  logic [15:0] div_eff, cnt_inc;
  logic        capture, oneshot_clr, tout_set;
  logic        unused_adr;

  assign acc        = wb.cyc & wb.stb & ~ack_q;
  assign wr         = acc & wb.we;
  assign sel        = wb.adr[2:0];
  assign w1c        = (wr && sel == 3'd5) ? wb.wdata[3:0] : 4'd0;
  assign unused_adr = ^wb.adr[15:3];

  assign pwm_in = sync_q[SYNC_STAGES-1] ^ ctrl_q[3];
  assign rise   = pwm_in & ~pwm_q;
  assign fall   = ~pwm_in & pwm_q;

  // DIVISOR=0 behaves as 1; the status flag reports the bad setting.
  assign div_eff  = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
  assign tick     = (state_q != StIdle) && (div_q == div_eff - 16'd1);
  assign cnt_sat  = (cnt_q == 16'hFFFF);
  assign cnt_inc  = (tick && !cnt_sat) ? cnt_q + 16'd1 : cnt_q;
  assign tout_hit = (timeout_q != 16'd0) && (cnt_inc >= timeout_q) && !rise;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    hi_cnt_d    = hi_cnt_q;
    capture     = 1'b0;
    oneshot_clr = 1'b0;
    tout_set    = 1'b0;
    if (state_q != StIdle && !ctrl_q[0]) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d    = '0;
          hi_cnt_d = '0;
          if (ctrl_q[0]) state_d = StArm;
        end
        StArm: begin
          if (rise) begin
            cnt_d   = '0;
            state_d = StHigh;
          end else if (tout_hit) begin
            cnt_d    = '0;
            tout_set = 1'b1;
          end
        end
        StHigh: begin
          if (tout_hit) begin
            cnt_d    = '0;
            tout_set = 1'b1;
            state_d  = StArm;
          end else if (fall) begin
            hi_cnt_d = cnt_inc;
            state_d  = StLow;
          end
        end
        StLow: begin
          if (rise) begin
            capture = 1'b1;
            cnt_d   = '0;
            if (ctrl_q[1]) begin
              state_d = StHigh;
            end else begin
              state_d     = StIdle;
              oneshot_clr = 1'b1;
            end
          end else if (tout_hit) begin
            cnt_d    = '0;
            tout_set = 1'b1;
            state_d  = StArm;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Prescaler phase restarts on every rise so captures are aligned to the edge.
  always_comb begin
    div_d = tick ? 16'd0 : div_q + 16'd1;
    if (state_q == StIdle || rise || tout_set) div_d = 16'd0;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (oneshot_clr) ctrl_d[0] = 1'b0;
    if (wr && sel == 3'd0) ctrl_d = wb.wdata[3:0];
  end

  always_comb begin
    rdata_d = 16'd0;
    case (sel)
      3'd0:    rdata_d = {12'd0, ctrl_q};
      3'd1:    rdata_d = divisor_q;
      3'd2:    rdata_d = timeout_q;
      3'd3:    rdata_d = period_q;
      3'd4:    rdata_d = high_q;
      3'd5:    rdata_d = {11'd0, pwm_q, divinv_q, ovf_q, tout_q, valid_q};
      default: rdata_d = 16'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      pwm_q     <= 1'b0;
      ctrl_q    <= 4'd0;
      divisor_q <= 16'd1;
      timeout_q <= 16'd0;
      period_q  <= 16'd0;
      high_q    <= 16'd0;
      valid_q   <= 1'b0;
      tout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      divinv_q  <= 1'b0;
      cnt_q     <= 16'd0;
      hi_cnt_q  <= 16'd0;
      div_q     <= 16'd0;
      ack_q     <= 1'b0;
      rdata_q   <= 16'd0;
      irq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], i_pwm};
      pwm_q    <= pwm_in;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      hi_cnt_q <= hi_cnt_d;
      div_q    <= div_d;
      ack_q    <= acc;
      irq_q    <= ctrl_q[2] & (valid_q | tout_q);
      if (acc) rdata_q <= rdata_d;
      if (wr && sel == 3'd1) divisor_q <= wb.wdata;
      if (wr && sel == 3'd2) timeout_q <= wb.wdata;
      if (capture) begin
        period_q <= cnt_inc;
        high_q   <= hi_cnt_q;
      end
      // Hardware sets take priority over a same-cycle write-one-to-clear.
      valid_q  <= (valid_q & ~w1c[0]) | capture;
      tout_q   <= (tout_q & ~w1c[1]) | tout_set;
      ovf_q    <= (ovf_q & ~w1c[2]) | (tick & cnt_sat);
      divinv_q <= (divinv_q & ~w1c[3]) | (divisor_q == 16'd0);
    end
  end

  assign wb.ack   = ack_q;
  assign wb.rdata = rdata_q;
  assign o_irq    = irq_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed bench for pwm_capture; expected captures come from a cycle-count
// model of the waveform the bench itself generates.
module tb_pwm_capture;

  logic clk = 1'b0;
  logic rst;
  logic pwm;
  logic irq;
  int   total = 0;
  int   bad   = 0;

  pwm_capture_if bus();

  pwm_capture #(.SYNC_STAGES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .wb    (bus),
    .i_pwm (pwm),
    .o_irq (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: a capture is the number of whole prescaler periods in the measured span.
  function automatic logic [15:0] model_ticks(input int cycles, input int divisor);
    int d;
    int q;
    d = (divisor == 0) ? 1 : divisor;
    q = cycles / d;
    return (q > 65535) ? 16'hFFFF : 16'(q);
  endfunction

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = {13'd0, a}; bus.wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.ack && n < 20);
    check_eq("wr_ack", {15'd0, bus.ack}, 16'd1);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [15:0] d);
    int n;
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = {13'd0, a};
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.ack && n < 20);
    check_eq("rd_ack", {15'd0, bus.ack}, 16'd1);
    d = bus.rdata;
    bus.cyc = 1'b0; bus.stb = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] rd;
    wb_read(a, rd);
    check_eq(tag, rd, exp);
  endtask

  // Called at a falling clock edge; keeps the pin at lvl for exactly n cycles.
  task automatic pin_hold(input logic lvl, input int n);
    pwm = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic train(input int h, input int l, input int k);
    @(negedge clk);
    pin_hold(1'b0, 4);
    repeat (k) begin
      pin_hold(1'b1, h);
      pin_hold(1'b0, l);
    end
  endtask

  task automatic quiesce();
    wb_write(3'd0, 16'h0000);
    @(negedge clk);
    pin_hold(1'b0, 8);
  endtask

  initial begin
    int h, l, dv;
    logic [15:0] exp_st;
    rst = 1'b1; pwm = 1'b0;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {15'd0, bus.ack}, 16'd0);
    check_eq("rst_irq", {15'd0, irq}, 16'd0);
    check_eq("rst_rdata", bus.rdata, 16'd0);
    @(negedge clk); rst = 1'b0;
    read_check("rst_ctrl", 3'd0, 16'h0000);
    read_check("rst_div", 3'd1, 16'h0001);
    read_check("rst_tout", 3'd2, 16'h0000);
    read_check("rst_period", 3'd3, 16'h0000);
    read_check("rst_high", 3'd4, 16'h0000);
    read_check("rst_status", 3'd5, 16'h0000);
    wb_write(3'd6, 16'hBEEF);
    read_check("reg6", 3'd6, 16'h0000);

    // Directed: 30 high / 70 low, irq enabled.
    wb_write(3'd1, 16'd1);
    wb_write(3'd0, 16'h0007);
    train(30, 70, 3);
    pin_hold(1'b1, 5);
    read_check("dir_period", 3'd3, 16'd100);
    read_check("dir_high", 3'd4, 16'd30);
    read_check("dir_status", 3'd5, 16'h0011);
    check_eq("dir_irq", {15'd0, irq}, 16'd1);
    quiesce();

    // Randomized continuous-mode captures across divisors, including the invalid 0.
    for (int t = 0; t < 8; t++) begin
      dv = (t == 0) ? 0 : (t == 1) ? 4 : int'($urandom_range(1, 5));
      h  = (t == 1) ? 40 : int'($urandom_range(6, 50));
      l  = (t == 1) ? 60 : int'($urandom_range(6, 50));
      wb_write(3'd1, 16'(dv));
      wb_write(3'd2, 16'd0);
      wb_write(3'd5, 16'h000F);
      wb_write(3'd0, 16'h0003);
      train(h, l, 2);
      pin_hold(1'b1, 6);
      read_check("rnd_period", 3'd3, model_ticks(h + l, dv));
      read_check("rnd_high", 3'd4, model_ticks(h, dv));
      exp_st = 16'h0011 | ((dv == 0) ? 16'h0008 : 16'h0000);
      read_check("rnd_status", 3'd5, exp_st);
      check_eq("rnd_irq", {15'd0, irq}, 16'd0);
      quiesce();
    end

    // Timeout with pin stuck low, then stuck high.
    wb_write(3'd1, 16'd1);
    wb_write(3'd2, 16'd50);
    wb_write(3'd5, 16'h000F);
    wb_write(3'd0, 16'h0005);
    repeat (43) @(posedge clk);
    read_check("tout_early", 3'd5, 16'h0000);
    repeat (10) @(posedge clk);
    read_check("tout_set", 3'd5, 16'h0002);
    repeat (2) @(posedge clk);
    #1;
    check_eq("tout_irq", {15'd0, irq}, 16'd1);
    wb_write(3'd5, 16'h0002);
    repeat (2) @(posedge clk);
    #1;
    check_eq("tout_irq_clr", {15'd0, irq}, 16'd0);
    @(negedge clk);
    pin_hold(1'b1, 120);
    read_check("tout_level", 3'd5, 16'h0012);
    quiesce();

    // One-shot: only the first period is captured and enable self-clears.
    wb_write(3'd2, 16'd0);
    wb_write(3'd5, 16'h000F);
    wb_write(3'd0, 16'h0005);
    train(20, 30, 2);
    read_check("os_ctrl", 3'd0, 16'h0004);
    read_check("os_period", 3'd3, 16'd50);
    read_check("os_high", 3'd4, 16'd20);
    check_eq("os_irq", {15'd0, irq}, 16'd1);
    train(10, 10, 3);
    read_check("os_period_kept", 3'd3, 16'd50);
    quiesce();

    // W1C of valid landing on the same edge as a new capture.
    wb_write(3'd5, 16'h000F);
    wb_write(3'd0, 16'h0003);
    train(20, 20, 2);
    pwm = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 16'd5; bus.wdata = 16'h0001;
    @(posedge clk); #1;
    check_eq("race_ack", {15'd0, bus.ack}, 16'd1);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    read_check("race_valid", 3'd5, 16'h0011);
    wb_write(3'd5, 16'h0001);
    read_check("w1c_valid", 3'd5, 16'h0010);
    quiesce();

    // Saturation: a high phase longer than the counter range.
    wb_write(3'd5, 16'h000F);
    wb_write(3'd0, 16'h0003);
    train(66000, 10, 1);
    pin_hold(1'b1, 6);
    read_check("ovf_high", 3'd4, model_ticks(66000, 1));
    read_check("ovf_period", 3'd3, model_ticks(66010, 1));
    read_check("ovf_status", 3'd5, 16'h0015);
    quiesce();

    // Reset while in the high phase of a capture.
    wb_write(3'd0, 16'h0003);
    @(negedge clk);
    pin_hold(1'b0, 4);
    pin_hold(1'b1, 10);
    read_check("pre_rst_ctrl", 3'd0, 16'h0003);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_rst_ack", {15'd0, bus.ack}, 16'd0);
    check_eq("mid_rst_rdata", bus.rdata, 16'd0);
    check_eq("mid_rst_irq", {15'd0, irq}, 16'd0);
    @(negedge clk); rst = 1'b0;
    read_check("mid_rst_ctrl", 3'd0, 16'h0000);
    read_check("mid_rst_div", 3'd1, 16'h0001);
    read_check("mid_rst_period", 3'd3, 16'h0000);
    read_check("mid_rst_high", 3'd4, 16'h0000);
    read_check("mid_rst_status", 3'd5, 16'h0010);
    train(20, 20, 2);
    pin_hold(1'b1, 5);
    read_check("post_rst_period", 3'd3, 16'h0000);
    read_check("post_rst_status", 3'd5, 16'h0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
